axis_packet_capture: RTL

Parametrised AXI-Stream sink that captures packets into an internal buffer under push-button control, and exposes the buffered words through a read port. It counts accepted words and whole packets and drives the board's 8-digit seven-segment display with a selectable statistic. It sits at the end of the AXI-Stream test chain on the Nexys A7, as the next-generation packet counter with configurable width, depth, packet-boundary-aware arming, overflow handling and a read-back port.

---
 rtl/axis_packet_capture.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axis_packet_capture.sv
// AXI-Stream packet capture sink: push-button armed, packet-boundary aware,
// with a read-back buffer port and a seven-segment statistics display.
module axis_packet_capture #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4096,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resentn,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic [1:0]        disp_sel,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       word_count,
  output logic [15:0]       pkt_count,
  output logic              overflow,
  output logic [31:0]       sevenseg,
  output logic [7:0]        digital_enable
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_IN_PKT = 2'd2;
  localparam logic [1:0] ST_FULL   = 2'd3;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic              start_meta_q, start_meta_d;
  logic              start_sync_q, start_sync_d;
  logic              start_prev_q, start_prev_d;
  logic              press_q, press_d;
  logic              tready_q, tready_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       word_count_q, word_count_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic [AW:0]       last_len_q, last_len_d;
  logic [AW:0]       beat_cnt_q, beat_cnt_d;
  logic              overflow_q, overflow_d;
  logic              stop_pending_q, stop_pending_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [31:0]       sevenseg_q, sevenseg_d;
  logic [7:0]        digital_enable_q, digital_enable_d;

  logic              accept;
  logic              fills;
  logic [AW:0]       word_inc;
  logic [AW:0]       beat_inc;
  logic [31:0]       disp_val;

  assign accept   = s_axis_tvalid & tready_q;
  assign word_inc = word_count_q + 1'b1;
  assign beat_inc = beat_cnt_q + 1'b1;
  assign fills    = (word_inc == FULL_COUNT);

  always_comb begin
    start_meta_d   = start;
    start_sync_d   = start_meta_q;
    start_prev_d   = start_sync_q;
    press_d        = start_sync_q & ~start_prev_q;
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    word_count_d   = word_count_q;
    pkt_count_d    = pkt_count_q;
    last_len_d     = last_len_q;
    beat_cnt_d     = beat_cnt_q;
    overflow_d     = overflow_q;
    stop_pending_d = stop_pending_q;

    if (clear) begin
      state_d        = ST_IDLE;
      wr_ptr_d       = '0;
      word_count_d   = '0;
      pkt_count_d    = '0;
      last_len_d     = '0;
      beat_cnt_d     = '0;
      overflow_d     = 1'b0;
      stop_pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_q) state_d = ST_ARMED;
        end
        ST_ARMED, ST_IN_PKT: begin
          if (press_q && state_q == ST_IN_PKT) stop_pending_d = 1'b1;
          if (accept) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            word_count_d = word_inc;
            beat_cnt_d   = beat_inc;
            // A full buffer wins over packet completion and any stop request.
            if (fills) begin
              state_d        = ST_FULL;
              stop_pending_d = 1'b0;
              beat_cnt_d     = '0;
              if (s_axis_tlast) begin
                pkt_count_d = pkt_count_q + 1'b1;
                last_len_d  = beat_inc;
              end else begin
                overflow_d  = 1'b1;
              end
            end else if (s_axis_tlast) begin
              pkt_count_d    = pkt_count_q + 1'b1;
              last_len_d     = beat_inc;
              beat_cnt_d     = '0;
              stop_pending_d = 1'b0;
              state_d        = (stop_pending_q || press_q) ? ST_IDLE : ST_ARMED;
            end else begin
              stop_pending_d = stop_pending_q | press_q;
              state_d        = ST_IN_PKT;
            end
          end else if (press_q && state_q == ST_ARMED) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_FULL;
        end
      endcase
    end

    tready_d = ((state_d == ST_ARMED) && (word_count_d != FULL_COUNT)) ||
               (state_d == ST_IN_PKT);
  end

  always_comb begin
    case (disp_sel)
      2'd0:    disp_val = 32'(word_count_q);
      2'd1:    disp_val = 32'(pkt_count_q);
      2'd2:    disp_val = 32'(last_len_q);
      default: disp_val = {27'd0, overflow_q, 2'b00, state_q};
    endcase
    sevenseg_d = disp_val;
    digital_enable_d = '0;
    for (int i = 0; i < 8; i++) begin
      digital_enable_d[i] = (disp_val[4*i +: 4] != 4'h0) || (i == 0);
    end
    rd_data_d = mem[rd_addr];
  end

  // Buffer storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (accept && !clear) mem[wr_ptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge resentn) begin
    if (!resentn) begin
      state_q          <= ST_IDLE;
      start_meta_q     <= 1'b0;
      start_sync_q     <= 1'b0;
      start_prev_q     <= 1'b0;
      press_q          <= 1'b0;
      tready_q         <= 1'b0;
      wr_ptr_q         <= '0;
      word_count_q     <= '0;
      pkt_count_q      <= '0;
      last_len_q       <= '0;
      beat_cnt_q       <= '0;
      overflow_q       <= 1'b0;
      stop_pending_q   <= 1'b0;
      rd_data_q        <= '0;
      sevenseg_q       <= '0;
      digital_enable_q <= 8'h01;
    end else begin
      state_q          <= state_d;
      start_meta_q     <= start_meta_d;
      start_sync_q     <= start_sync_d;
      start_prev_q     <= start_prev_d;
      press_q          <= press_d;
      tready_q         <= tready_d;
      wr_ptr_q         <= wr_ptr_d;
      word_count_q     <= word_count_d;
      pkt_count_q      <= pkt_count_d;
      last_len_q       <= last_len_d;
      beat_cnt_q       <= beat_cnt_d;
      overflow_q       <= overflow_d;
      stop_pending_q   <= stop_pending_d;
      rd_data_q        <= rd_data_d;
      sevenseg_q       <= sevenseg_d;
      digital_enable_q <= digital_enable_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign rd_data        = rd_data_q;
  assign word_count     = word_count_q;
  assign pkt_count      = pkt_count_q;
  assign overflow       = overflow_q;
  assign sevenseg       = sevenseg_q;
  assign digital_enable = digital_enable_q;

endmodule
